fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch stage with a decoupling prefetch queue. It replaces the single-register fetch path with three parts: a free-running fetch PC, a one-request-in-flight synchronous instruction-memory interface, and a DEPTH-entry FIFO of {pc, ir} pairs. It sits between the instruction memory and decode. Decode consumes instructions through a valid/ready handshake, and execute redirects the stream through `pc_sel`. A redirect flushes all queued and in-flight instructions.

## Interface
- `WORD_WIDTH`, 32: PC and instruction width (riscv::WORD_WIDTH).
- `ADDR_WIDTH`, riscv::IMEM_ADDR_WIDTH: word-address width of instruction memory.
- `DEPTH`, 4: queue entries; power of two, ≥4.
- `RESET_PC`, 32'h0000_0000: first fetch address; bits [1:0] must be 0.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `pc_sel`  in  2  00 = sequential, 01 = jal/bxx redirect, 10 = jalr redirect, 11 = treated as 00.
- `jal_bxx_tgt`  in  WORD_WIDTH  target used when `pc_sel`=01.
- `jalr_tgt`  in  WORD_WIDTH  target used when `pc_sel`=10.
- `imem_rd`  out  1  read strobe; memory samples `imem_addr` on this edge.
- `imem_addr`  out  ADDR_WIDTH  word address, = request_pc[ADDR_WIDTH+1:2].
- `imem_data`  in  WORD_WIDTH  read data, valid in the cycle after the `imem_rd` cycle.
- `out_valid`  out  1  head entry present.
- `out_ready`  in  1  decode accepts the head entry this cycle.
- `pc`  out  WORD_WIDTH  PC of the head entry.
- `ir`  out  WORD_WIDTH  instruction of the head entry (rv32i::ir_t-compatible).

## Operation
- **State:**
  - `fpc` is the next sequential fetch PC.
  - `inflight` is a flag, registered from the previous cycle's `imem_rd`.
  - The FIFO has rd/wr pointers of log2(DEPTH) bits with wrap-around, plus a `count` of log2(DEPTH)+1 bits.
- **Redirect:** `redirect` = (`pc_sel`==01 or 10).
  - The target is the selected target with bits [1:0] forced to 0.
- **Request:** `imem_rd` = resetn & (redirect | (count + inflight < DEPTH)).
  - No credit is taken for a same-cycle dequeue.
  - `imem_addr` is formed from the target when `redirect`=1; otherwise from `fpc`.
- **Request register:** `req_pc` is registered alongside `inflight`; it holds the PC of the outstanding request.
- **PC update on issue:** `fpc` ← issued_pc + 4, modulo 2^WORD_WIDTH (wraps silently).
- **PC update on redirect without issue:** not possible, since redirect always issues.
- **Enqueue:** when `inflight`=1 and `redirect`=0, write {`req_pc`, `imem_data`} at the wr pointer.
  - A response arriving in a redirect cycle is discarded.
- **Dequeue:** when `out_valid` & `out_ready`.
  - This handshake completes even in a redirect cycle: decode owns that instruction.
- **Flush:** on `redirect`, count ← 0 and rd = wr pointer. Any enqueue in that cycle is suppressed.
- **Simultaneous enqueue and dequeue:** count is unchanged and both pointers advance.
- **Count bound:** count never exceeds DEPTH, so no overflow check on enqueue is needed.
- **Empty queue:** `out_valid`=0. `pc` and `ir` hold the last head value and are don't-care to decode.
- **Outputs:** `pc` and `ir` come from the rd-pointer entry. No bypass from `imem_data`: an enqueued entry becomes visible the next cycle.
- **Reset (asynchronous, mid-operation allowed):**
  - fpc = RESET_PC, inflight = 0, count = 0, pointers = 0.
  - `out_valid`=0, `imem_rd`=0, `pc`=RESET_PC, `ir`=32'h0000_0013 (NOP).
  - Any in-flight memory response is ignored.

## Timing
- **After reset:** `resetn` rises before edge E0. Request RESET_PC is issued at E0, its data is enqueued at E1, and `out_valid`=1 with `pc`=RESET_PC after E1. Latency is 2 cycles.
- **Redirect:** redirect in cycle N (sampled at edge N) issues the target at edge N. `out_valid` for the target is asserted 2 cycles after N.
- **Steady state:** with `out_ready`=1, one instruction per cycle and consecutive PCs (count=1, inflight=1).
- **Stall:** with `out_ready`=0, requests stop once count+inflight = DEPTH. Nothing is lost or reordered.
- **Restart:** after the stall is released, throughput returns to 1/cycle with no gap.

## Test plan
- **Reset / sequential fetch:** RESET_PC=0x100, `out_ready`=1, memory returns the word address as data → `pc`=0x100, 0x104, 0x108…; first `out_valid` 2 cycles after reset release; no gaps.
- **Backpressure:** `out_ready`=0 for 10 cycles → `imem_rd` deasserts after count=4; on release, the sequence continues at the next PC with no duplicate or skip.
- **jal/bxx redirect:** `pc_sel`=01, `jal_bxx_tgt`=0x200 while the queue is full → queue flushed, in-flight response dropped, next `out_valid` has `pc`=0x200 two cycles later.
- **jalr alignment:** `pc_sel`=10, `jalr_tgt`=0x3_0007 → request at PC 0x3_0004; `pc_sel`=11 behaves as sequential.
- **Redirect with same-cycle handshake:** redirect with `out_valid`=`out_ready`=1 → that head is consumed exactly once; nothing older appears afterwards.
- **Wrap and mid-operation reset:**
  - Fetch at 0xFFFF_FFFC → next PC 0x0.
  - Assert `resetn`=0 mid-stream → outputs immediately take their reset values (`ir`=0x13, `out_valid`=0).

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: free-running fetch PC, one-outstanding-request imem port,
// and a DEPTH-entry {pc, ir} prefetch queue drained by decode through valid/ready.
module fetch_queue #(
    parameter int unsigned           WORD_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [1:0]            pc_sel,
    input  logic [WORD_WIDTH-1:0] jal_bxx_tgt,
    input  logic [WORD_WIDTH-1:0] jalr_tgt,
    output logic                  imem_rd,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [WORD_WIDTH-1:0] imem_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] pc,
    output logic [WORD_WIDTH-1:0] ir
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [WORD_WIDTH-1:0] NOP = WORD_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        SEL_SEQ     = 2'b00,
        SEL_JAL_BXX = 2'b01,
        SEL_JALR    = 2'b10,
        SEL_SEQ_ALT = 2'b11
    } pc_sel_e;

    logic [WORD_WIDTH-1:0] fpc;
    logic [WORD_WIDTH-1:0] req_pc;
    logic [WORD_WIDTH-1:0] tgt;
    logic [WORD_WIDTH-1:0] issue_pc;
    logic                  inflight;
    logic                  redirect;
    logic                  enq;
    logic                  deq;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic [CW:0]           pending;

    logic [WORD_WIDTH-1:0] pc_mem [DEPTH];
    logic [WORD_WIDTH-1:0] ir_mem [DEPTH];

    // NOTE: every always_comb output gets a value before any conditional logic, so no latch can be inferred.
    always_comb begin
        redirect = (pc_sel_e'(pc_sel) == SEL_JAL_BXX) || (pc_sel_e'(pc_sel) == SEL_JALR);
        tgt      = (pc_sel_e'(pc_sel) == SEL_JALR) ? jalr_tgt : jal_bxx_tgt;
        tgt[1:0] = 2'b00;
        issue_pc = redirect ? tgt : fpc;
        pending  = {1'b0, count} + (CW+1)'(inflight);
    end

    // Credit counts queued entries plus the outstanding request; a same-cycle pop earns none.
    assign imem_rd   = resetn && (redirect || (pending < (CW+1)'(DEPTH)));
    assign imem_addr = issue_pc[ADDR_WIDTH+1:2];

    assign out_valid = (count != '0);
    assign enq       = inflight && !redirect;
    assign deq       = out_valid && out_ready;
    assign pc        = pc_mem[rd_ptr];
    assign ir        = ir_mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fpc      <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_rd;
            if (imem_rd) begin
                fpc    <= issue_pc + WORD_WIDTH'(4);
                req_pc <= issue_pc;
            end
            if (redirect) begin
                // Flush: the in-flight response and all queued entries are dropped.
                count  <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (enq) wr_ptr <= wr_ptr + PW'(1);
                if (deq) rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(enq) - CW'(deq);
            end
        end
    end

    // NOTE: the queue storage is reset on purpose: the head outputs must show RESET_PC/NOP during reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem[i] <= RESET_PC;
                ir_mem[i] <= NOP;
            end
        end else if (enq) begin
            pc_mem[wr_ptr] <= req_pc;
            ir_mem[wr_ptr] <= imem_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: reset/backpressure vector table, directed redirect/wrap/reset
// sequences, then random stimulus checked against a consecutive-PC stream model.
module tb_fetch_queue;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic [31:0] jal_bxx_tgt = '0;
    logic [31:0] jalr_tgt = '0;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [31:0] imem_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] ir;

    int tests = 0;
    int fails = 0;

    fetch_queue #(
        .WORD_WIDTH(32),
        .ADDR_WIDTH(16),
        .DEPTH(4),
        .RESET_PC(RPC)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .pc_sel(pc_sel),
        .jal_bxx_tgt(jal_bxx_tgt),
        .jalr_tgt(jalr_tgt),
        .imem_rd(imem_rd),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .pc(pc),
        .ir(ir)
    );

    always #5 clk = ~clk;

    // Synchronous memory whose word at each address is the word address itself.
    always @(posedge clk) begin
        if (imem_rd) imem_data <= {16'h0000, imem_addr};
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] ir_of(input logic [31:0] p);
        return {16'h0000, p[17:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic rdy, input logic [1:0] sel, input logic [31:0] tgt);
        @(negedge clk);
        out_ready   = rdy;
        pc_sel      = sel;
        jal_bxx_tgt = tgt;
        jalr_tgt    = tgt;
        #1;
    endtask

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_rd;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [31:0] p, input logic d);
        vec_t t;
        t.ready = r; t.exp_valid = v; t.exp_pc = p; t.exp_rd = d;
        return t;
    endfunction

    vec_t vecs [21];

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic [1:0]  sel;
        logic        rdy;
        int          since;
        int          r;

        // Reset release, first fetch latency, 10-cycle stall and restart.
        vecs[0]  = mk(1'b1, 1'b0, RPC,          1'b1);
        vecs[1]  = mk(1'b1, 1'b0, RPC,          1'b1);
        vecs[2]  = mk(1'b1, 1'b1, 32'h100,      1'b1);
        vecs[3]  = mk(1'b1, 1'b1, 32'h104,      1'b1);
        vecs[4]  = mk(1'b1, 1'b1, 32'h108,      1'b1);
        vecs[5]  = mk(1'b0, 1'b1, 32'h10C,      1'b1);
        vecs[6]  = mk(1'b0, 1'b1, 32'h10C,      1'b1);
        for (int i = 7; i < 15; i++) vecs[i] = mk(1'b0, 1'b1, 32'h10C, 1'b0);
        vecs[15] = mk(1'b1, 1'b1, 32'h10C,      1'b0);
        vecs[16] = mk(1'b1, 1'b1, 32'h110,      1'b1);
        vecs[17] = mk(1'b1, 1'b1, 32'h114,      1'b1);
        vecs[18] = mk(1'b1, 1'b1, 32'h118,      1'b1);
        vecs[19] = mk(1'b1, 1'b1, 32'h11C,      1'b1);
        vecs[20] = mk(1'b1, 1'b1, 32'h120,      1'b1);

        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_rd",    imem_rd,   0);
        check("reset_pc",    pc,        RPC);
        check("reset_ir",    ir,        32'h13);

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            resetn    = 1'b1;
            out_ready = vecs[i].ready;
            pc_sel    = 2'b00;
            #1;
            check($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_rd", i),    imem_rd,   vecs[i].exp_rd);
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
                check($sformatf("vec%0d_ir", i), ir, ir_of(vecs[i].exp_pc));
            end
        end

        // jalr target alignment, then pc_sel=11 behaving as sequential.
        cycle(1'b1, 2'b10, 32'h0003_0007);
        check("jalr_rd",   imem_rd,   1);
        check("jalr_addr", imem_addr, 16'hC001);
        cycle(1'b1, 2'b00, 32'h0);
        check("jalr_flush_valid", out_valid, 0);
        cycle(1'b1, 2'b00, 32'h0);
        check("jalr_head_valid", out_valid, 1);
        check("jalr_head_pc",    pc,        32'h0003_0004);
        check("jalr_head_ir",    ir,        32'h0000_C001);
        cycle(1'b1, 2'b11, 32'h0000_0800);
        check("sel11_pc",   pc,        32'h0003_0008);
        check("sel11_addr", imem_addr, 16'hC004);
        cycle(1'b1, 2'b00, 32'h0);
        check("sel11_next_pc", pc, 32'h0003_000C);

        // jal redirect while entries are queued and a response is in flight.
        cycle(1'b0, 2'b00, 32'h0);
        cycle(1'b0, 2'b00, 32'h0);
        cycle(1'b0, 2'b01, 32'h0000_0200);
        check("jal_rd",   imem_rd,   1);
        check("jal_addr", imem_addr, 16'h0080);
        cycle(1'b1, 2'b00, 32'h0);
        check("jal_flush_valid", out_valid, 0);
        cycle(1'b1, 2'b00, 32'h0);
        check("jal_head_valid", out_valid, 1);
        check("jal_head_pc",    pc,        32'h200);
        check("jal_head_ir",    ir,        32'h80);
        cycle(1'b1, 2'b00, 32'h0);
        check("jal_next_pc", pc, 32'h204);

        // Redirect with a same-cycle handshake: head consumed once, nothing older follows.
        cycle(1'b1, 2'b01, 32'h0000_0400);
        check("hs_redirect_valid", out_valid, 1);
        check("hs_redirect_pc",    pc,        32'h208);
        cycle(1'b1, 2'b00, 32'h0);
        check("hs_flush_valid", out_valid, 0);
        cycle(1'b1, 2'b00, 32'h0);
        check("hs_target_pc", pc, 32'h400);
        cycle(1'b1, 2'b00, 32'h0);
        check("hs_next_pc", pc, 32'h404);

        // PC wrap past the top of the address space.
        cycle(1'b1, 2'b01, 32'hFFFF_FFF8);
        check("wrap_addr0", imem_addr, 16'hFFFE);
        cycle(1'b1, 2'b00, 32'h0);
        check("wrap_addr1", imem_addr, 16'hFFFF);
        cycle(1'b1, 2'b00, 32'h0);
        check("wrap_pc0",   pc,        32'hFFFF_FFF8);
        check("wrap_addr2", imem_addr, 16'h0000);
        cycle(1'b1, 2'b00, 32'h0);
        check("wrap_pc1", pc, 32'hFFFF_FFFC);
        check("wrap_ir1", ir, 32'h0000_FFFF);
        cycle(1'b1, 2'b00, 32'h0);
        check("wrap_pc2", pc, 32'h0);
        check("wrap_ir2", ir, 32'h0);

        // Mid-stream asynchronous reset, then the 2-cycle restart latency again.
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_rd",    imem_rd,   0);
        check("midrst_ir",    ir,        32'h13);
        check("midrst_pc",    pc,        RPC);
        @(negedge clk);
        resetn    = 1'b1;
        out_ready = 1'b1;
        pc_sel    = 2'b00;
        #1;
        check("rel_valid0", out_valid, 0);
        check("rel_addr0",  imem_addr, 16'h0040);
        cycle(1'b1, 2'b00, 32'h0);
        check("rel_valid1", out_valid, 0);
        cycle(1'b1, 2'b00, 32'h0);
        check("rel_valid2", out_valid, 1);
        check("rel_pc",     pc,        RPC);
        check("rel_ir",     ir,        32'h40);

        // Random phase: accepted stream must be consecutive PCs from the last redirect target.
        tgt = $urandom;
        cycle(1'b0, 2'b10, tgt);
        exp_pc = {tgt[31:2], 2'b00};
        since  = 1;
        for (int n = 0; n < 400; n++) begin
            rdy = ($urandom_range(0, 3) != 0);
            r   = $urandom_range(0, 15);
            sel = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
            tgt = $urandom;
            cycle(rdy, sel, tgt);
            check("rand_valid", out_valid, (since >= 2) ? 1 : 0);
            if (out_valid && out_ready) begin
                check("rand_pc", pc, exp_pc);
                check("rand_ir", ir, ir_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
            if (sel == 2'b01 || sel == 2'b10) begin
                check("rand_redirect_rd",   imem_rd,   1);
                check("rand_redirect_addr", imem_addr, {16'h0000, tgt[17:2]});
                exp_pc = {tgt[31:2], 2'b00};
                since  = 1;
            end else begin
                since = since + 1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
